// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: one operation in flight, IDLE/EXEC/RESP.
// Define ALU_ARB_RR_EN for round-robin tie breaking; the default is fixed priority to requester 0.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_c
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, data_q;
  logic [2:0]       op_q;
  logic             id_q;
  logic             gnt_vld, gnt_id, tie_id, acc, resp_hs;

`ifdef ALU_ARB_RR_EN
  logic last_q;

  // Reset value 1 hands requester 0 the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   last_q <= 1'b1;
    else if (acc) last_q <= gnt_id;
  end

  assign tie_id = ~last_q;
`else
  assign tie_id = 1'b0;
`endif

  // rst_n gates the grant so ready stays low while reset is held, even with valid high.
  always_comb begin
    gnt_vld = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
    gnt_id  = (req0_valid && req1_valid) ? tie_id : req1_valid;
  end

  assign req0_ready = gnt_vld & ~gnt_id;
  assign req1_ready = gnt_vld &  gnt_id;
  assign acc        = gnt_vld;
  assign resp_hs    = (state_q == RESP) && (id_q ? resp1_ready : resp0_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc)     state_d = EXEC;
      EXEC:                 state_d = RESP;
      RESP:    if (resp_hs) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        a_q  <= gnt_id ? req1_a  : req0_a;
        b_q  <= gnt_id ? req1_b  : req0_b;
        op_q <= gnt_id ? req1_op : req0_op;
        id_q <= gnt_id;
      end
      if (state_q == EXEC) data_q <= alu_c;
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign resp_data   = data_q;
  assign resp0_valid = (state_q == RESP) && !id_q;
  assign resp1_valid = (state_q == RESP) &&  id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, directed multi-cycle corners, then random traffic
// checked against a transaction-level model. The ALU itself is modelled here.
module tb_alu_arbiter;
  localparam int W = 32;
`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b1;
  logic [1:0] rv = '0, rr = '0;
  logic [W-1:0] ra [2];
  logic [W-1:0] rb [2];
  logic [2:0] rop [2];
  logic req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [W-1:0] resp_data, alu_a, alu_b, alu_c;
  logic [2:0] alu_op;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a >> b[4:0];
      3'd5: return $signed(a) >>> b[4:0];
      3'd6: return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  assign alu_c = alu_ref(alu_a, alu_b, alu_op);

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rv[0]), .req0_ready(req0_ready), .req0_a(ra[0]), .req0_b(rb[0]), .req0_op(rop[0]),
    .req1_valid(rv[1]), .req1_ready(req1_ready), .req1_a(ra[1]), .req1_b(rb[1]), .req1_op(rop[1]),
    .resp0_valid(resp0_valid), .resp0_ready(rr[0]),
    .resp1_valid(resp1_valid), .resp1_ready(rr[1]),
    .resp_data(resp_data), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c)
  );

  wire [1:0] rdy = {req1_ready, req0_ready};
  wire [1:0] rsp = {resp1_valid, resp0_valid};

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Entered at the sampling point of a cycle with valids already driven.
  task automatic do_txn(input int eid, input logic [W-1:0] edata, input bit keep, input string nm);
    int n = 0;
    while (rdy == 2'b00 && n < 10) begin @(posedge clk); #2; n++; end
    chk({nm, " ready"}, W'(rdy), W'(2'b01 << eid));
    @(posedge clk); #1;
    if (!keep) rv[eid] = 1'b0;
    #1;
    chk({nm, " exec rsp"}, W'(rsp), '0);
    chk({nm, " exec rdy"}, W'(rdy), '0);
    @(posedge clk); #2;
    chk({nm, " resp vld"}, W'(rsp), W'(2'b01 << eid));
    chk({nm, " resp data"}, resp_data, edata);
    rr[eid] = 1'b1;
    @(posedge clk); #1;
    rr = '0;
    #1;
    chk({nm, " resp drop"}, W'(rsp), '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; rv = '0; rr = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    ra[id] = a; rb[id] = b; rop[id] = op; rv[id] = 1'b1;
  endtask

  typedef struct {
    int         id;
    logic [W-1:0] a, b;
    logic [2:0] op;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl [7];

  initial begin
    bit pend [2];
    bit out_v;
    int out_id, out_c, last, w;
    logic [W-1:0] out_d;
    logic [1:0] erdy, ersp;

    tbl[0] = '{0, 32'd10,         32'd100,        3'd0, 32'd110};
    tbl[1] = '{0, 32'hA600_0000,  32'd4,          3'd5, 32'hFA60_0000};
    tbl[2] = '{1, 32'd6,          32'd1,          3'd4, 32'd3};
    tbl[3] = '{1, 32'd100,        32'd10,         3'd1, 32'd90};
    tbl[4] = '{0, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  3'd6, 32'hFF00_FF00};
    tbl[5] = '{1, 32'h1234_5678,  32'h0000_FFFF,  3'd7, 32'hEDCB_0000};
    tbl[6] = '{0, 32'hFFFF_FFFF,  32'd1,          3'd0, 32'd0};
    for (int i = 0; i < 2; i++) begin ra[i] = '0; rb[i] = '0; rop[i] = '0; end

    #1 rst_n = 1'b0;
    #1;
    chk("reset rdy", W'(rdy), '0);
    chk("reset rsp", W'(rsp), '0);
    chk("reset data", resp_data, '0);
    chk("reset alu_a", alu_a, '0);
    chk("reset alu_b", alu_b, '0);
    chk("reset alu_op", W'(alu_op), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 7; i++) begin
      set_req(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].op);
      #1;
      do_txn(tbl[i].id, tbl[i].exp, 1'b0, $sformatf("vec%0d", i));
    end

    // Simultaneous requests right after reset: requester 0 first under either policy.
    do_reset();
    set_req(0, 32'd100, 32'd10, 3'd1);
    set_req(1, 32'd5, 32'd4, 3'd2);
    #1;
    do_txn(0, 32'd90, 1'b0, "tie first");
    do_txn(1, 32'd4, 1'b0, "tie second");

    // Both held valid for four operations.
    do_reset();
    set_req(0, 32'd1, 32'd2, 3'd0);
    set_req(1, 32'd8, 32'd3, 3'd1);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (RR && (k % 2 == 1)) do_txn(1, 32'd5, 1'b1, $sformatf("hold op%0d", k));
      else                    do_txn(0, 32'd3, 1'b1, $sformatf("hold op%0d", k));
    end
    rv = '0;

    // Response back-pressure for 5 cycles while requester 0 is waiting.
    set_req(1, 32'd5, 32'd4, 3'd3);
    #1;
    begin
      int n = 0;
      while (!req1_ready && n < 10) begin @(posedge clk); #2; n++; end
    end
    chk("stall accept", W'(rdy), W'(2'b10));
    @(posedge clk); #1; rv[1] = 1'b0;
    @(posedge clk); #1;
    set_req(0, 32'd20, 32'd22, 3'd0);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d vld", k), W'(rsp), W'(2'b10));
      chk($sformatf("stall%0d data", k), resp_data, 32'd5);
      chk($sformatf("stall%0d rdy", k), W'(rdy), '0);
      @(posedge clk); #2;
    end
    rr[1] = 1'b1;
    @(posedge clk); #1; rr = '0; #1;
    do_txn(0, 32'd42, 1'b0, "after stall");

    // Reset pulse in EXEC.
    set_req(0, 32'd7, 32'd9, 3'd0);
    #1;
    begin
      int n = 0;
      while (!req0_ready && n < 10) begin @(posedge clk); #2; n++; end
    end
    @(posedge clk); #2;
    chk("exec alu_a", alu_a, 32'd7);
    chk("exec alu_b", alu_b, 32'd9);
    rst_n = 1'b0;
    #1;
    chk("rst rdy", W'(rdy), '0);
    chk("rst rsp", W'(rsp), '0);
    chk("rst data", resp_data, '0);
    chk("rst alu_a", alu_a, '0);
    chk("rst alu_b", alu_b, '0);
    chk("rst alu_op", W'(alu_op), '0);
    rv = '0;
    @(posedge clk); #1; rst_n = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("post rst%0d rsp", k), W'(rsp), '0);
      @(posedge clk); #2;
    end
    set_req(1, 32'd6, 32'd1, 3'd4);
    #1;
    do_txn(1, 32'd3, 1'b0, "post rst txn");

    // Random traffic against the transaction model.
    do_reset();
    pend[0] = 0; pend[1] = 0; out_v = 0; out_id = 0; out_c = 0; out_d = '0; last = 1;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          ra[i] = $urandom; rb[i] = $urandom; rop[i] = 3'($urandom_range(7));
        end
        rv[i] = pend[i];
      end
      rr = 2'($urandom_range(3));
      #1;
      erdy = '0; ersp = '0; w = 0;
      if (!out_v && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) w = (RR && last == 0) ? 1 : 0;
        else                    w = pend[0] ? 0 : 1;
        erdy = 2'b01 << w;
      end
      if (out_v && c >= out_c + 2) ersp = 2'b01 << out_id;
      chk($sformatf("rnd%0d rdy", c), W'(rdy), W'(erdy));
      chk($sformatf("rnd%0d rsp", c), W'(rsp), W'(ersp));
      if (ersp != 0) chk($sformatf("rnd%0d data", c), resp_data, out_d);
      if (ersp != 0 && rr[out_id]) out_v = 1'b0;
      if (erdy != 0) begin
        out_v = 1'b1; out_id = w; out_c = c; last = w;
        out_d = alu_ref(ra[w], rb[w], rop[w]);
        pend[w] = 1'b0;
      end
    end
    rv = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
- REQ-001: Parameter WIDTH, 32, operand/result width.
- REQ-002: clk  input  1  single clock, rising edge.
- REQ-003: rst_n  input  1  reset, asynchronous, active-low.
- REQ-004: req0_valid / req1_valid  input  1  requester N has an operation pending.
- REQ-005: req0_ready / req1_ready  output  1  block accepts requester N this cycle.
- REQ-006: req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands A, B of requester N.
- REQ-007: req0_op / req1_op  input  3  ALUOp of requester N.
- REQ-008: resp0_valid / resp1_valid  output  1  result available for requester N.
- REQ-009: resp0_ready / resp1_ready  input  1  requester N takes the result.
- REQ-010: resp_data  output  WIDTH  result, shared by both requesters.
- REQ-011: alu_a, alu_b  output  WIDTH  drive the shared combinational ALU's A and B.
- REQ-012: alu_op  output  3  drives the ALU's ALUOp.
- REQ-013: alu_c  input  WIDTH  ALU result C.

Function
- REQ-014: FSM states IDLE, EXEC, RESP; transitions IDLE->EXEC on request handshake, EXEC->RESP unconditionally after one cycle, RESP->IDLE on response handshake.
- REQ-015: reqN_ready is high only in IDLE and only for the granted requester; at most one ready high at any time; both low in EXEC and RESP.
- REQ-016: Grant in IDLE: a sole valid requester is granted; if both are valid, arbitration per REQ-027/REQ-028.
- REQ-017: Request handshake (reqN_valid & reqN_ready at clk edge) latches a, b, op and the requester id into internal registers.
- REQ-018: alu_a, alu_b, alu_op are driven from the latched registers at all times and hold their last values outside EXEC.
- REQ-019: At the EXEC->RESP edge, alu_c is captured into resp_data.
- REQ-020: In RESP, respN_valid is high only for the latched id; resp_data and respN_valid are held stable until respN_ready=1.
- REQ-021: Latency: respN_valid rises 2 cycles after the request handshake edge; minimum 3 cycles per operation; no pipelining, no internal queue.
- REQ-022: The block does not interpret ALUOp; values 6/7 are forwarded unchanged and alu_c is returned as-is.
- REQ-023: A request that arrives while not in IDLE waits; the requester holds valid and operands stable until ready.

Reset
- REQ-024: rst_n=0 immediately (asynchronously) forces IDLE and clears req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data, alu_a, alu_b, alu_op and all latched registers to 0.
- REQ-025: Reset mid-operation (EXEC or RESP) discards the transaction; no response is issued after reset release.
- REQ-026: After reset release, the last-grant register points at requester 1, so requester 0 wins the first tie.

Configuration
- REQ-027: With macro ALU_ARB_RR_EN defined, ties are resolved round-robin: the requester not granted last wins; the last-grant register updates on every request handshake.
- REQ-028: With ALU_ARB_RR_EN undefined, fixed priority applies: requester 0 always wins ties and the last-grant register is absent.

Verification
- REQ-029: Only req0 valid, A=10 B=100 op=0 -> accepted in IDLE; resp0_valid rises 2 cycles later; resp_data=110; resp1_valid stays 0.
- REQ-030: After reset, req0 (A=100 B=10 op=1) and req1 (A=5 B=4 op=2) valid in the same cycle -> req0 served first with resp_data=90, then req1 with resp_data=4.
- REQ-031: Both valid continuously for 4 operations -> grant order 0,1,0,1 with ALU_ARB_RR_EN defined; 0,0,0,0 without it.
- REQ-032: resp1_ready held low 5 cycles during RESP, A=5 B=4 op=3 -> resp1_valid=1 and resp_data=5 stable throughout; both reqN_ready stay 0 and no new accept occurs.
- REQ-033: req0 A=0xA6000000 B=4 op=5 and req1 A=6 B=1 op=4 -> resp_data=0xFA600000 and 3 respectively, each delivered to the correct requester.
- REQ-034: rst_n pulsed low during EXEC -> all outputs 0 within the same cycle; after release, IDLE with no stale response and the next request completes normally.
